// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encodings, the next-PC select encodings and the
// default width of the statistics counters.
package hazard_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned ADDR_W    = 32;

    // FSM states: normal run, load-use bubble issued, memory freeze
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_LU   = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // Next-PC select: sequential, branch target, jump target
    typedef enum logic [1:0] {
        PCS_SEQ = 2'd0,
        PCS_BR  = 2'd1,
        PCS_JMP = 2'd2
    } pcs_t;

endpackage

// File: rtl/hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational comparator of the decode-stage source
// registers against the EX- and MEM-stage destinations.
//   hz_lu  : load in EX writes a register the decode instruction reads
//   hz_raw : any in-flight writer (EX or MEM) targets a register read in decode
// Register 0 never creates a hazard; rt only counts when the decode
// instruction actually reads it.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] IFID_rs,
    input  logic [REG_W-1:0] IFID_rt,
    input  logic             IFID_usesrt,
    input  logic [REG_W-1:0] IDEX_rd,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [REG_W-1:0] EXMEM_rd,
    input  logic             EXMEM_RegWrite,
    output logic             hz_lu,
    output logic             hz_raw
);

    logic idex_match_c;
    logic exmem_match_c;

    // Does a destination collide with a source actually read in decode
    always_comb begin
        idex_match_c  = (IDEX_rd != '0) &&
                        ((IDEX_rd == IFID_rs) || (IFID_usesrt && (IDEX_rd == IFID_rt)));
        exmem_match_c = (EXMEM_rd != '0) &&
                        ((EXMEM_rd == IFID_rs) || (IFID_usesrt && (EXMEM_rd == IFID_rt)));
        hz_lu         = IDEX_MemRead && idex_match_c;
        hz_raw        = (IDEX_RegWrite && idex_match_c) || (EXMEM_RegWrite && exmem_match_c);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline controller for the 5-stage MIPS core.
// Decides PC/pipeline-register write enables, flushes and the next-PC
// select every cycle, and keeps saturating stall/flush statistics.
// Priority: rst > mem_busy (freeze) > redirect > hazard stall > advance.
//
// Build option: define HAZ_FWD_EN when the datapath forwards; then only
// load-use hazards stall. Otherwise any RAW against EX or MEM stalls.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   IFID_* / IDEX_* / EXMEM_*      stage fields watched for hazards/redirects
//   mem_busy                       data memory has not finished MEM access
//   pc_write, *_write              register load enables (combinational)
//   *_flush                        register clears (combinational)
//   pc_sel, pc_target              next-PC select and target (combinational)
//   stall_cnt, flush_cnt           saturating statistics (registered)
//   state                          FSM state for debug (registered)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  IFID_rs,
    input  logic [REG_W-1:0]  IFID_rt,
    input  logic              IFID_usesrt,
    input  logic [REG_W-1:0]  IDEX_rd,
    input  logic              IDEX_MemRead,
    input  logic              IDEX_RegWrite,
    input  logic [REG_W-1:0]  EXMEM_rd,
    input  logic              EXMEM_RegWrite,
    input  logic              EXMEM_Branch,
    input  logic              EXMEM_ALUzero,
    input  logic              EXMEM_Jump,
    input  logic [ADDR_W-1:0] EXMEM_branchpc,
    input  logic [ADDR_W-1:0] EXMEM_jumpaddr,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              IFID_write,
    output logic              IDEX_write,
    output logic              EXMEM_write,
    output logic              MEMWB_write,
    output logic              IFID_flush,
    output logic              IDEX_flush,
    output logic              EXMEM_flush,
    output logic [1:0]        pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hz_lu_c;
    logic hz_raw_c;
    logic stall_c;
    logic unused_c;
    logic redir_c;
    logic stall_inc_c;
    logic flush_inc_c;
    pcs_t pc_sel_c;

    hazard_detect u_hazard_detect (
        .IFID_rs        (IFID_rs),
        .IFID_rt        (IFID_rt),
        .IFID_usesrt    (IFID_usesrt),
        .IDEX_rd        (IDEX_rd),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_RegWrite  (IDEX_RegWrite),
        .EXMEM_rd       (EXMEM_rd),
        .EXMEM_RegWrite (EXMEM_RegWrite),
        .hz_lu          (hz_lu_c),
        .hz_raw         (hz_raw_c)
    );

    // Stall source depends on whether the datapath forwards
`ifdef HAZ_FWD_EN
    assign stall_c  = hz_lu_c;
    assign unused_c = hz_raw_c;
`else
    assign stall_c  = hz_raw_c;
    assign unused_c = hz_lu_c;
`endif

    assign redir_c = (EXMEM_Branch && EXMEM_ALUzero) || EXMEM_Jump;

    // Per-cycle control decode and next-state selection
    always_comb begin
        pc_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_write  = 1'b1;
        EXMEM_write = 1'b1;
        MEMWB_write = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        pc_sel_c    = PCS_SEQ;
        pc_target   = '0;
        state_d     = ST_RUN;
        stall_inc_c = 1'b0;
        flush_inc_c = 1'b0;

        if (rst) begin
            // Outputs show the post-reset decode; registers clear below
            state_d = ST_RUN;
        end else if (mem_busy) begin
            // Freeze everything; EX/MEM is held so a pending redirect survives
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_write = 1'b0;
            MEMWB_write = 1'b0;
            state_d     = ST_WAIT;
            stall_inc_c = 1'b1;
        end else if (redir_c) begin
            // Squash the three younger slots while PC loads the target
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            if (EXMEM_Jump) begin
                pc_sel_c  = PCS_JMP;
                pc_target = EXMEM_jumpaddr;
            end else begin
                pc_sel_c  = PCS_BR;
                pc_target = EXMEM_branchpc;
            end
            flush_inc_c = 1'b1;
            state_d     = ST_RUN;
        end else if (stall_c) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_flush  = 1'b1;
            state_d     = ST_LU;
            stall_inc_c = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_sel    = pc_sel_c;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver issues directed then random
// stimulus and pushes the expected response of a rule-level model; a
// monitor pops and compares every cycle.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IFID_rs, IFID_rt, IDEX_rd, EXMEM_rd;
    logic        IFID_usesrt, IDEX_MemRead, IDEX_RegWrite, EXMEM_RegWrite;
    logic        EXMEM_Branch, EXMEM_ALUzero, EXMEM_Jump, mem_busy;
    logic [31:0] EXMEM_branchpc, EXMEM_jumpaddr;
    logic        pc_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write;
    logic        IFID_flush, IDEX_flush, EXMEM_flush;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_usesrt(IFID_usesrt),
        .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .EXMEM_rd(EXMEM_rd), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_Branch(EXMEM_Branch), .EXMEM_ALUzero(EXMEM_ALUzero), .EXMEM_Jump(EXMEM_Jump),
        .EXMEM_branchpc(EXMEM_branchpc), .EXMEM_jumpaddr(EXMEM_jumpaddr),
        .mem_busy(mem_busy),
        .pc_write(pc_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
        .EXMEM_write(EXMEM_write), .MEMWB_write(MEMWB_write),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
        .pc_sel(pc_sel), .pc_target(pc_target),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, busy, usesrt, memread, idex_rw, exmem_rw, br, zero, jmp;
        bit [4:0] rs, rt, idex_rd, exmem_rd;
        bit [31:0] bpc, jaddr;
    } stim_t;

    // {pc_write, IFID_w, IDEX_w, EXMEM_w, MEMWB_w, IFID_f, IDEX_f, EXMEM_f, sel, target}
    typedef struct {
        logic [41:0] ctrl;
        int st, sc, fc;
    } exp_t;

    exp_t q[$];
    int   m_st, m_sc, m_fc;
    int   n_checks = 0, n_pass = 0;
    bit   done = 0;

    function automatic stim_t quiet();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // True when register r is nonzero and read by the decode instruction
    function automatic bit reads(input stim_t s, input bit [4:0] r);
        return (r != 0) && ((s.rs == r) || (s.usesrt && (s.rt == r)));
    endfunction

    function automatic bit hazard(input stim_t s);
`ifdef HAZ_FWD_EN
        return s.memread && reads(s, s.idex_rd);
`else
        return (s.idex_rw && reads(s, s.idex_rd)) || (s.exmem_rw && reads(s, s.exmem_rd));
`endif
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic apply(input stim_t s);
        exp_t  e;
        string act;
        bit    redir;
        @(negedge clk);
        #1;
        rst = s.rst; mem_busy = s.busy;
        IFID_rs = s.rs; IFID_rt = s.rt; IFID_usesrt = s.usesrt;
        IDEX_rd = s.idex_rd; IDEX_MemRead = s.memread; IDEX_RegWrite = s.idex_rw;
        EXMEM_rd = s.exmem_rd; EXMEM_RegWrite = s.exmem_rw;
        EXMEM_Branch = s.br; EXMEM_ALUzero = s.zero; EXMEM_Jump = s.jmp;
        EXMEM_branchpc = s.bpc; EXMEM_jumpaddr = s.jaddr;

        redir = (s.br && s.zero) || s.jmp;
        if (s.rst)          act = "adv";
        else if (s.busy)    act = "freeze";
        else if (redir)     act = "redir";
        else if (hazard(s)) act = "stall";
        else                act = "adv";

        e.st = m_st; e.sc = m_sc; e.fc = m_fc;
        case (act)
            "freeze": e.ctrl = {8'b0000_0000, 2'd0, 32'd0};
            "redir":  e.ctrl = s.jmp ? {8'b1111_1111, 2'd2, s.jaddr}
                                     : {8'b1111_1111, 2'd1, s.bpc};
            "stall":  e.ctrl = {8'b0011_1010, 2'd0, 32'd0};
            default:  e.ctrl = {8'b1111_1000, 2'd0, 32'd0};
        endcase
        q.push_back(e);

        if (s.rst) begin
            m_st = 0; m_sc = 0; m_fc = 0;
        end else begin
            case (act)
                "freeze": begin m_st = 2; m_sc = sat(m_sc); end
                "redir":  begin m_st = 0; m_fc = sat(m_fc); end
                "stall":  begin m_st = 1; m_sc = sat(m_sc); end
                default:  m_st = 0;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [41:0] got, input logic [41:0] want,
                         input int cyc);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    endtask

    // Monitor: compare DUT outputs against the oldest expected entry
    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!(done && q.size() == 0)) begin
            @(negedge clk);
            #2;
            cyc++;
            if (cyc > 5000) begin
                n_checks++;
                $display("FAIL timeout: %0d entries still pending", q.size());
                break;
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("ctrl", {pc_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write,
                               IFID_flush, IDEX_flush, EXMEM_flush, pc_sel, pc_target},
                      e.ctrl, cyc);
                check("state", 42'(state), 42'(e.st), cyc);
                check("stall_cnt", 42'(stall_cnt), 42'(e.sc), cyc);
                check("flush_cnt", 42'(flush_cnt), 42'(e.fc), cyc);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Driver: directed scenarios, then random traffic
    initial begin : driver
        stim_t s;
        rst = 1'b1; mem_busy = 0;
        IFID_rs = 0; IFID_rt = 0; IFID_usesrt = 0; IDEX_rd = 0; IDEX_MemRead = 0;
        IDEX_RegWrite = 0; EXMEM_rd = 0; EXMEM_RegWrite = 0; EXMEM_Branch = 0;
        EXMEM_ALUzero = 0; EXMEM_Jump = 0; EXMEM_branchpc = 0; EXMEM_jumpaddr = 0;
        m_st = 0; m_sc = 0; m_fc = 0;
        repeat (2) @(posedge clk);

        // Reset decode, then load-use followed by advance
        s = quiet(); s.rst = 1; apply(s);
        s = quiet(); s.memread = 1; s.idex_rw = 1; s.idex_rd = 5; s.rs = 5; apply(s);
        apply(quiet());
        // Taken branch to 0x40
        s = quiet(); s.br = 1; s.zero = 1; s.bpc = 32'h40; s.jaddr = 32'h99; apply(s);
        apply(quiet());
        // Jump with a simultaneous load-use hazard
        s = quiet(); s.jmp = 1; s.jaddr = 32'h1234; s.br = 1; s.bpc = 32'h80;
        s.memread = 1; s.idex_rw = 1; s.idex_rd = 7; s.rt = 7; s.usesrt = 1; apply(s);
        apply(quiet());
        // Memory freeze for 3 cycles with a pending taken branch
        s = quiet(); s.br = 1; s.zero = 1; s.bpc = 32'h200;
        s.busy = 1; repeat (3) apply(s);
        s.busy = 0; apply(s);
        apply(quiet());
        // RAW on rt through EX then MEM (stalls only without forwarding)
        s = quiet(); s.idex_rw = 1; s.idex_rd = 3; s.rt = 3; s.usesrt = 1; apply(s);
        s = quiet(); s.exmem_rw = 1; s.exmem_rd = 3; s.rt = 3; s.usesrt = 1; apply(s);
        s = quiet(); s.rt = 3; s.usesrt = 1; apply(s);
        // Saturation, then reset mid-WAIT
        s = quiet(); s.busy = 1; repeat (20) apply(s);
        s.rst = 1; s.br = 1; s.zero = 1; s.bpc = 32'h44; apply(s);
        apply(quiet());

        // Random traffic with a small register pool to provoke matches
        for (int i = 0; i < 600; i++) begin
            s = quiet();
            s.rst      = ($urandom_range(0, 29) == 0);
            s.busy     = ($urandom_range(0, 4) == 0);
            s.rs       = 5'($urandom_range(0, 3));
            s.usesrt   = 1'($urandom_range(0, 1));
            s.rt       = s.usesrt ? 5'($urandom_range(0, 3)) : 5'd0;
            s.idex_rd  = 5'($urandom_range(0, 3));
            s.memread  = 1'($urandom_range(0, 1));
            s.idex_rw  = 1'($urandom_range(0, 1));
            s.exmem_rd = 5'($urandom_range(0, 3));
            s.exmem_rw = 1'($urandom_range(0, 1));
            s.br       = ($urandom_range(0, 4) == 0);
            s.zero     = 1'($urandom_range(0, 1));
            s.jmp      = ($urandom_range(0, 7) == 0);
            s.bpc      = $urandom;
            s.jaddr    = $urandom;
            apply(s);
        end
        apply(quiet());
        done = 1;
    end

endmodule
